// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: instruction decode, control-unit states
// and ALU operation encodings.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_LOAD   = 4'd1,
      I_STORE  = 4'd2,
      I_MOVE   = 4'd3,
      I_ADD    = 4'd4,
      I_SUB    = 4'd5,
      I_AND    = 4'd6,
      I_OR     = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNZERO = 4'd10,
      I_BNEG   = 4'd11,
      I_BNNEG  = 4'd12,
      I_BOV    = 4'd13,
      I_BNOV   = 4'd14,
      I_HALT   = 4'd15
   } decoded_instruction_type;

   typedef enum logic [3:0] {
      FETCH_ADDR = 4'd0,
      FETCH_LOAD = 4'd1,
      DECODE     = 4'd2,
      LOAD_ADDR  = 4'd3,
      LOAD_WB    = 4'd4,
      STORE      = 4'd5,
      ALU_WB     = 4'd6,
      BRANCH     = 4'd7,
      HALTED     = 4'd8
   } cu_state_type;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_AND = 2'b11
   } alu_op_type;

endpackage

// File: rtl/control_unit_branch_eval.sv
// Combinational branch resolution: taken/not-taken for the branch family,
// always 0 for any non-branch opcode.
module branch_eval
   import k_and_s_pkg::*;
(
   input  decoded_instruction_type instr,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    taken
);

   logic ov;
   assign ov = unsigned_overflow | signed_overflow;

   always_comb begin
      taken = 1'b0;
      unique case (instr)
         I_BRANCH: taken = 1'b1;
         I_BZERO:  taken = zero_op;
         I_BNZERO: taken = ~zero_op;
         I_BNEG:   taken = neg_op;
         I_BNNEG:  taken = ~neg_op;
         I_BOV:    taken = ov;
         I_BNOV:   taken = ~ov;
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the K&S datapath: fetch/decode/execute FSM, all strobes
// derived from state, plus a saturating retired-instruction counter.
module control_unit
   import k_and_s_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  decoded_instruction_type decoded_instruction,
   input  logic                    zero_op,
   input  logic                    neg_op,
   input  logic                    unsigned_overflow,
   input  logic                    signed_overflow,
   output logic                    branch,
   output logic                    pc_enable,
   output logic                    ir_enable,
   output logic                    addr_sel,
   output logic                    c_sel,
   output logic [1:0]              operation,
   output logic                    write_reg_enable,
   output logic                    flags_reg_enable,
   output logic                    ram_write_enable,
   output logic                    halt,
   output logic [CNT_W-1:0]        retired_count,
   output cu_state_type            state_dbg
);

   cu_state_type            state, next_state;
   decoded_instruction_type op_q;
   logic                    taken;
   logic                    retire;

   branch_eval u_branch_eval (
      .instr             (decoded_instruction),
      .zero_op           (zero_op),
      .neg_op            (neg_op),
      .unsigned_overflow (unsigned_overflow),
      .signed_overflow   (signed_overflow),
      .taken             (taken)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH_ADDR;
         op_q  <= I_NOP;
      end else begin
         state <= next_state;
         // Opcode copy keeps the ALU op stable through ALU_WB.
         if (state == DECODE)
            op_q <= decoded_instruction;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         FETCH_ADDR: next_state = FETCH_LOAD;
         FETCH_LOAD: next_state = DECODE;
         DECODE: begin
            unique case (decoded_instruction)
               I_LOAD:  next_state = LOAD_ADDR;
               I_STORE: next_state = STORE;
               I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                        next_state = ALU_WB;
               I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                        next_state = taken ? BRANCH : FETCH_ADDR;
               I_HALT:  next_state = HALTED;
               default: next_state = FETCH_ADDR;
            endcase
         end
         LOAD_ADDR:  next_state = LOAD_WB;
         LOAD_WB:    next_state = FETCH_ADDR;
         STORE:      next_state = FETCH_ADDR;
         ALU_WB:     next_state = FETCH_ADDR;
         BRANCH:     next_state = FETCH_ADDR;
         HALTED:     next_state = HALTED;
         default:    next_state = FETCH_ADDR;
      endcase
   end

   always_comb begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = OP_OR;
      write_reg_enable = 1'b0;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      halt             = 1'b0;
      unique case (state)
         FETCH_ADDR: addr_sel = 1'b1;
         FETCH_LOAD: begin
            addr_sel  = 1'b1;
            ir_enable = 1'b1;
            pc_enable = 1'b1;
         end
         LOAD_WB:    write_reg_enable = 1'b1;
         STORE:      ram_write_enable = 1'b1;
         ALU_WB: begin
            c_sel            = 1'b1;
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            unique case (op_q)
               I_ADD:   operation = OP_ADD;
               I_SUB:   operation = OP_SUB;
               I_AND:   operation = OP_AND;
               I_OR:    operation = OP_OR;
               // MOVE is Ra OR Ra and must not disturb the flags.
               default: flags_reg_enable = 1'b0;
            endcase
         end
         BRANCH: begin
            pc_enable = 1'b1;
            branch    = 1'b1;
         end
         HALTED:     halt = 1'b1;
         default:    ;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      if (next_state == FETCH_ADDR &&
          (state == DECODE || state == LOAD_WB || state == STORE ||
           state == ALU_WB || state == BRANCH))
         retire = 1'b1;
      if (next_state == HALTED && state != HALTED)
         retire = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         retired_count <= '0;
      else if (retire && retired_count != {CNT_W{1'b1}})
         retired_count <= retired_count + 1'b1;
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors per instruction,
// reset abort, halt absorption and counter saturation on a 4-bit instance.
module tb_control_unit;
   import k_and_s_pkg::*;

   // Strobe vector: {branch,pc_en,ir_en,addr_sel,c_sel,op[1:0],wr,flags,ram_we,halt}
   localparam logic [10:0] V_FA   = 11'h080;
   localparam logic [10:0] V_FL   = 11'h380;
   localparam logic [10:0] V_DEC  = 11'h000;
   localparam logic [10:0] V_LA   = 11'h000;
   localparam logic [10:0] V_LWB  = 11'h008;
   localparam logic [10:0] V_ST   = 11'h002;
   localparam logic [10:0] V_SUB  = 11'h06C;
   localparam logic [10:0] V_ADD  = 11'h05C;
   localparam logic [10:0] V_AND  = 11'h07C;
   localparam logic [10:0] V_OR   = 11'h04C;
   localparam logic [10:0] V_MOV  = 11'h048;
   localparam logic [10:0] V_BR   = 11'h600;
   localparam logic [10:0] V_HALT = 11'h001;

   logic                    clk;
   logic                    rst;
   decoded_instruction_type decoded_instruction;
   logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;

   logic        branch, pc_enable, ir_enable, addr_sel, c_sel;
   logic [1:0]  operation;
   logic        write_reg_enable, flags_reg_enable, ram_write_enable, halt;
   logic [15:0] retired_count;
   cu_state_type state_dbg;

   logic        s_branch, s_pc_enable, s_ir_enable, s_addr_sel, s_c_sel;
   logic [1:0]  s_operation;
   logic        s_write_reg_enable, s_flags_reg_enable, s_ram_write_enable, s_halt;
   logic [3:0]  s_retired_count;
   cu_state_type s_state_dbg;

   logic [10:0] exp_q[$];
   int          n_cmp;
   int          n_err;
   int          exp_cnt;

   control_unit #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op),
      .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
      .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
      .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
      .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
      .ram_write_enable(ram_write_enable), .halt(halt),
      .retired_count(retired_count), .state_dbg(state_dbg)
   );

   control_unit #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
      .zero_op(zero_op), .neg_op(neg_op),
      .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
      .branch(s_branch), .pc_enable(s_pc_enable), .ir_enable(s_ir_enable),
      .addr_sel(s_addr_sel), .c_sel(s_c_sel), .operation(s_operation),
      .write_reg_enable(s_write_reg_enable), .flags_reg_enable(s_flags_reg_enable),
      .ram_write_enable(s_ram_write_enable), .halt(s_halt),
      .retired_count(s_retired_count), .state_dbg(s_state_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] outs_now();
      return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
              write_reg_enable, flags_reg_enable, ram_write_enable, halt};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_prefix();
      exp_q.push_back(V_FA);
      exp_q.push_back(V_FL);
      exp_q.push_back(V_DEC);
   endtask

   // Plays exp_q one cycle per entry, then expects the next FETCH_ADDR and one more retirement.
   task automatic run_instr(input string tag, input decoded_instruction_type ins,
                            input logic [3:0] fl);
      logic [10:0] e;
      decoded_instruction = ins;
      {zero_op, neg_op, unsigned_overflow, signed_overflow} = fl;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, 32'(outs_now()), 32'(e));
         next_cycle();
      end
      exp_cnt++;
      check({tag, "_next_fetch"}, 32'(outs_now()), 32'(V_FA));
      check({tag, "_count"}, 32'(retired_count), 32'(exp_cnt));
      check({tag, "_sat_count"}, 32'(s_retired_count),
            32'((exp_cnt > 15) ? 15 : exp_cnt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      decoded_instruction = I_NOP;
      {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0000;
      next_cycle();
      next_cycle();
      check("reset_outputs", 32'(outs_now()), 32'(V_FA));
      check("reset_count", 32'(retired_count), 32'd0);
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_cnt = 0;
      do_reset();

      push_prefix();                                      run_instr("nop", I_NOP, 4'b0000);
      push_prefix(); exp_q.push_back(V_LA); exp_q.push_back(V_LWB);
                                                          run_instr("load", I_LOAD, 4'b0000);
      push_prefix(); exp_q.push_back(V_ST);               run_instr("store", I_STORE, 4'b0000);
      push_prefix(); exp_q.push_back(V_SUB);              run_instr("sub", I_SUB, 4'b0000);
      push_prefix(); exp_q.push_back(V_MOV);              run_instr("move", I_MOVE, 4'b0000);
      push_prefix(); exp_q.push_back(V_ADD);              run_instr("add", I_ADD, 4'b0000);
      push_prefix(); exp_q.push_back(V_AND);              run_instr("and", I_AND, 4'b0000);
      push_prefix(); exp_q.push_back(V_OR);               run_instr("or", I_OR, 4'b0000);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bzero_t", I_BZERO, 4'b1000);
      push_prefix();                                      run_instr("bzero_nt", I_BZERO, 4'b0000);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bnzero_t", I_BNZERO, 4'b0000);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bov_sov_t", I_BOV, 4'b0001);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bov_uov_t", I_BOV, 4'b0010);
      push_prefix();                                      run_instr("bov_nt", I_BOV, 4'b0000);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bnov_t", I_BNOV, 4'b0000);
      push_prefix();                                      run_instr("bnov_nt", I_BNOV, 4'b0001);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("bneg_t", I_BNEG, 4'b0100);
      push_prefix();                                      run_instr("bnneg_nt", I_BNNEG, 4'b0100);
      push_prefix(); exp_q.push_back(V_BR);               run_instr("branch", I_BRANCH, 4'b0000);

      // HALT: three cycles to HALTED, then absorbing with only halt high.
      decoded_instruction = I_HALT;
      push_prefix();
      while (exp_q.size() > 0) begin
         check("halt_seq", 32'(outs_now()), 32'(exp_q.pop_front()));
         next_cycle();
      end
      exp_cnt++;
      for (int i = 0; i < 20; i++) begin
         check("halted_outs", 32'(outs_now()), 32'(V_HALT));
         check("halted_count", 32'(retired_count), 32'(exp_cnt));
         decoded_instruction = (i % 2 == 0) ? I_LOAD : I_BRANCH;
         next_cycle();
      end
      do_reset();

      // Reset arriving during LOAD_ADDR aborts with no register write.
      decoded_instruction = I_LOAD;
      push_prefix();
      while (exp_q.size() > 0) begin
         check("abort_seq", 32'(outs_now()), 32'(exp_q.pop_front()));
         next_cycle();
      end
      check("abort_in_load_addr", 32'(outs_now()), 32'(V_LA));
      #2 rst = 1'b1;
      #1 check("abort_async_outs", 32'(outs_now()), 32'(V_FA));
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("abort_no_wr", 32'(write_reg_enable), 32'd0);
      end
      rst = 1'b0;
      exp_cnt = 0;
      check("abort_count", 32'(retired_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("abort_release_no_wr", 32'(write_reg_enable), 32'd0);
         next_cycle();
      end
      do_reset();

      // 17 NOPs: the 4-bit instance must stop at 15.
      for (int i = 0; i < 17; i++) begin
         push_prefix();
         run_instr("sat_nop", I_NOP, 4'b0000);
      end
      check("sat_final", 32'(s_retired_count), 32'd15);
      check("sat_main_final", 32'(retired_count), 32'd17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
